// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants and types for the handshaked data memory.
//   WORD_W / BYTES_PER_WORD : word geometry
//   state_t                 : responder FSM states
//   LANEn_LSB / lane_lsb()  : big-endian lane to bit-slice mapping
//                             (lane 0 = lowest address = bits [31:24])
package dmem_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int LANE0_LSB = 24;
    localparam int LANE1_LSB = 16;
    localparam int LANE2_LSB = 8;
    localparam int LANE3_LSB = 0;

    // LSB of the 8-bit slice that lane 'lane' occupies in a word.
    function automatic int lane_lsb(input int lane);
        return WORD_W - 8 * (lane + 1);
    endfunction

endpackage

// File: rtl/be_byte_ram.sv
// be_byte_ram: byte-organised storage with big-endian word access.
//   clk   : write clock
//   we    : commit a word store on this posedge
//   addr  : byte address of the most significant byte
//   wdata : store word (bits [31:24] go to addr)
//   rdata : combinational word read starting at addr
// Lane addresses wrap modulo DEPTH, so a word near the top of the
// array continues at byte 0. Contents are not reset.
module be_byte_ram
    import dmem_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [7:0] mem [DEPTH];
    logic [BYTES_PER_WORD-1:0][ADDR_W-1:0] lane_addr;

    for (genvar l = 0; l < BYTES_PER_WORD; l++) begin : g_lane
        // ADDR_W-bit add gives the modulo-DEPTH wrap for free
        assign lane_addr[l] = addr + ADDR_W'(l);
        assign rdata[lane_lsb(l) +: 8] = mem[lane_addr[l]];
    end

    always_ff @(posedge clk) begin
        if (we) begin
            for (int l = 0; l < BYTES_PER_WORD; l++) begin
                mem[lane_addr[l]] <= wdata[lane_lsb(l) +: 8];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: handshaked word load/store target with wait states.
//   clk, reset            : clock, async active-high reset
//   req_valid/req_ready   : request handshake
//   req_write             : 1 = store word, 0 = load word
//   req_addr              : byte address of the most significant byte
//   req_wdata             : store data
//   resp_valid/resp_ready : response handshake
//   resp_rdata            : load data, 0 for stores
//   resp_write            : echo of the accepted req_write
// One transaction in flight: IDLE accepts, ACCESS counts WAIT cycles
// then commits, RESP holds the result until the initiator takes it.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5,
    parameter int WAIT   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_write
);

    state_t            state;
    logic [3:0]        wait_cnt;
    logic              lat_write;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_wdata;
    logic [31:0]       ram_rdata;
    logic              commit;

    // The access happens on the ACCESS edge where the counter has run out;
    // a reset before that edge leaves the array untouched.
    assign commit = (state == ACCESS) && (wait_cnt == 4'd0);

    be_byte_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (commit && lat_write),
        .addr  (lat_addr),
        .wdata (lat_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_write <= 1'b0;
            wait_cnt   <= '0;
            lat_write  <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // ready is registered so it is low during reset and
                    // rises on the first edge afterwards
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        lat_write <= req_write;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        wait_cnt  <= 4'(WAIT);
                        req_ready <= 1'b0;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else begin
                        resp_rdata <= lat_write ? 32'd0 : ram_rdata;
                        resp_write <= lat_write;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_rdata <= '0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    req_ready  <= 1'b0;
                    resp_valid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule
